// File: rtl/aemb2_fill_pkg.sv
// Shared definitions for the AEMB2 line-fill engine: FSM encoding,
// Wishbone cycle-type / burst-type constants and the line-size to BTE mapping.
package aemb2_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Wrapping burst type matching a line of 2^lw words.
  function automatic logic [1:0] lw_to_bte(input int lw);
    case (lw)
      2:       lw_to_bte = BTE_WRAP4;
      3:       lw_to_bte = BTE_WRAP8;
      4:       lw_to_bte = BTE_WRAP16;
      default: lw_to_bte = BTE_LINEAR;
    endcase
  endfunction

endpackage

// File: rtl/aemb2_fill_beat.sv
// Beat/index counter for a line fill: loads the start word index, advances
// modulo 2^LW on each accepted beat and flags the final beat of the line.
module aemb2_fill_beat #(
  parameter int LW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [LW-1:0] start_i,
  input  logic          adv_i,
  output logic [LW-1:0] idx_o,
  output logic          last_o
);

  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] cnt_q, cnt_d;

  // Index wraps naturally at LW bits; the beat count is kept separately so
  // the final beat is known regardless of the start index.
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load_i) begin
      idx_d = start_i;
      cnt_d = '0;
    end else if (adv_i) begin
      idx_d = idx_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/aemb2_line_fill.sv
// Line-fill engine: Wishbone B3 burst master that copies one 2^LW-word line
// into the local SRAM. Define AEMB2_FILL_CRITICAL_FIRST_EN for critical-word-first wrapping bursts.
module aemb2_line_fill
  import aemb2_fill_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 32,
  parameter int LW  = 2,
  parameter int XAW = 30
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_i,
  input  logic [XAW-1:0] req_adr_i,
  output logic           busy_o,
  output logic           ack_o,
  output logic           err_o,
  output logic           wb_cyc_o,
  output logic           wb_stb_o,
  output logic [XAW-1:0] wb_adr_o,
  output logic [2:0]     wb_cti_o,
  output logic [1:0]     wb_bte_o,
  input  logic [DW-1:0]  wb_dat_i,
  input  logic           wb_ack_i,
  input  logic           wb_err_i,
  output logic [AW-1:0]  sram_adr_o,
  output logic [DW-1:0]  sram_dat_o,
  output logic           sram_wre_o,
  output logic           sram_ena_o
);

  fill_state_e    state_q, state_d;
  logic [XAW-1:0] base_q, base_d;
  logic [AW-1:0]  sram_adr_q, sram_adr_d;
  logic [DW-1:0]  sram_dat_q, sram_dat_d;
  logic           wre_q, wre_d;
  logic           err_q, err_d;

  logic [LW-1:0]  start_idx;
  logic [LW-1:0]  idx;
  logic           last_beat;
  logic           load;
  logic           adv;
  logic           in_fill;
  logic [XAW-1:0] beat_adr;

`ifdef AEMB2_FILL_CRITICAL_FIRST_EN
  localparam logic [1:0] BURST_BTE = lw_to_bte(LW);
  assign start_idx = req_adr_i[LW-1:0];
`else
  localparam logic [1:0] BURST_BTE = BTE_LINEAR;
  logic unused_req_low;
  assign unused_req_low = ^req_adr_i[LW-1:0];
  assign start_idx = '0;
`endif

  aemb2_fill_beat #(.LW(LW)) u_beat (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .start_i (start_idx),
    .adv_i   (adv),
    .idx_o   (idx),
    .last_o  (last_beat)
  );

  assign in_fill  = (state_q == ST_FILL);
  assign beat_adr = base_q | XAW'(idx);

  // DONE accepts a new request just like IDLE so a requester that keeps
  // req_i high gets its next fill on the DONE-exit edge.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    load       = 1'b0;
    adv        = 1'b0;
    wre_d      = 1'b0;
    sram_adr_d = sram_adr_q;
    sram_dat_d = sram_dat_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (req_i) begin
          state_d = ST_FILL;
          base_d  = {req_adr_i[XAW-1:LW], {LW{1'b0}}};
          load    = 1'b1;
        end
      end
      ST_FILL: begin
        // Error wins over a simultaneous ack: that word is dropped.
        if (wb_err_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (wb_ack_i) begin
          adv        = 1'b1;
          wre_d      = 1'b1;
          sram_adr_d = beat_adr[AW-1:0];
          sram_dat_d = wb_dat_i;
          if (last_beat) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      sram_adr_q <= '0;
      sram_dat_q <= '0;
      wre_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      sram_adr_q <= sram_adr_d;
      sram_dat_q <= sram_dat_d;
      wre_q      <= wre_d;
      err_q      <= err_d;
    end
  end

  // Bus outputs are gated by the state so reset forces them low at once.
  assign wb_cyc_o   = in_fill;
  assign wb_stb_o   = in_fill;
  assign wb_adr_o   = in_fill ? beat_adr : '0;
  assign wb_cti_o   = in_fill ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
  assign wb_bte_o   = in_fill ? BURST_BTE : BTE_LINEAR;

  assign busy_o     = (state_q != ST_IDLE);
  assign ack_o      = (state_q == ST_DONE);
  assign err_o      = err_q;
  assign sram_adr_o = sram_adr_q;
  assign sram_dat_o = sram_dat_q;
  assign sram_wre_o = wre_q;
  assign sram_ena_o = wre_q;

endmodule

// File: tb/tb_aemb2_line_fill.sv
// Self-checking bench for aemb2_line_fill: bus slave driver with wait states
// and error injection, SRAM-write scoreboard, reset and back-to-back scenarios.
module tb_aemb2_line_fill;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LW  = 2;
  localparam int XAW = 30;
  localparam int N   = 1 << LW;

`ifdef AEMB2_FILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif
  localparam logic [1:0] EXP_BTE = CRIT ? ((LW == 2) ? 2'b01 : (LW == 3) ? 2'b10 : 2'b11) : 2'b00;
  localparam logic [2:0] EXP_INCR = 3'b010;
  localparam logic [2:0] EXP_EOB  = 3'b111;

  logic           clk_i, rst_i;
  logic           req_i;
  logic [XAW-1:0] req_adr_i;
  logic           busy_o, ack_o, err_o;
  logic           wb_cyc_o, wb_stb_o;
  logic [XAW-1:0] wb_adr_o;
  logic [2:0]     wb_cti_o;
  logic [1:0]     wb_bte_o;
  logic [DW-1:0]  wb_dat_i;
  logic           wb_ack_i, wb_err_i;
  logic [AW-1:0]  sram_adr_o;
  logic [DW-1:0]  sram_dat_o;
  logic           sram_wre_o, sram_ena_o;

  aemb2_line_fill #(.AW(AW), .DW(DW), .LW(LW), .XAW(XAW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .req_adr_i  (req_adr_i),
    .busy_o     (busy_o),
    .ack_o      (ack_o),
    .err_o      (err_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_adr_o   (wb_adr_o),
    .wb_cti_o   (wb_cti_o),
    .wb_bte_o   (wb_bte_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .sram_adr_o (sram_adr_o),
    .sram_dat_o (sram_dat_o),
    .sram_wre_o (sram_wre_o),
    .sram_ena_o (sram_ena_o)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [AW+DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int n_ack_seen = 0;
  int n_err_seen = 0;
  int exp_acks = 0;
  int exp_errs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // SRAM write monitor and completion pulse counters
  always @(negedge clk_i) begin
    logic [AW+DW-1:0] e;
    if (!rst_i) begin
      if (ack_o) n_ack_seen++;
      if (err_o) n_err_seen++;
      if (sram_wre_o || sram_ena_o) begin
        chk("sram_ena_eq_wre", sram_ena_o, sram_wre_o);
        chk("sram_write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sram_adr", sram_adr_o, e[AW+DW-1:DW]);
          chk("sram_dat", sram_dat_o, e[DW-1:0]);
        end
      end
    end
  end

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_cyc"},  wb_cyc_o, 0);
    chk({pfx, "_stb"},  wb_stb_o, 0);
    chk({pfx, "_adr"},  wb_adr_o, 0);
    chk({pfx, "_cti"},  wb_cti_o, 0);
    chk({pfx, "_bte"},  wb_bte_o, 0);
    chk({pfx, "_busy"}, busy_o, 0);
    chk({pfx, "_ack"},  ack_o, 0);
    chk({pfx, "_err"},  err_o, 0);
    chk({pfx, "_wre"},  sram_wre_o, 0);
    chk({pfx, "_ena"},  sram_ena_o, 0);
    chk({pfx, "_sadr"}, sram_adr_o, 0);
    chk({pfx, "_sdat"}, sram_dat_o, 0);
  endtask

  // One line fill. Called at a point just after a posedge (or at a negedge)
  // with the DUT idle, unless pre_acc says the fill was accepted at the last edge.
  task automatic run_fill(input logic [XAW-1:0] adr, input int maxw, input int err_beat,
                          input bit next_v, input logic [XAW-1:0] next_adr, input bit pre_acc);
    logic [XAW-1:0] base, exp_adr;
    logic [LW-1:0]  idx;
    int edges, total_waits, waits;
    base = adr & ~XAW'(N - 1);
    idx  = CRIT ? adr[LW-1:0] : '0;
    edges = 0;
    total_waits = 0;
    if (!pre_acc) begin
      req_i = 1'b1;
      req_adr_i = adr;
      @(posedge clk_i); #1;
    end
    for (int b = 0; b < N; b++) begin
      exp_adr = base | XAW'(idx);
      if (b == N - 1) begin
        req_i = next_v;
        req_adr_i = next_v ? next_adr : XAW'($urandom);
      end else if (b == err_beat) begin
        req_i = 1'b0;
      end else begin
        req_i = 1'($urandom_range(0, 1));
        req_adr_i = XAW'($urandom);
      end
      waits = $urandom_range(0, maxw);
      total_waits += waits;
      for (int w = 0; w <= waits; w++) begin
        if (w == waits) begin
          wb_ack_i = 1'b1;
          wb_err_i = (b == err_beat);
          wb_dat_i = $urandom;
        end
        @(negedge clk_i);
        chk("fill_cyc", wb_cyc_o, 1);
        chk("fill_stb", wb_stb_o, 1);
        chk("fill_busy", busy_o, 1);
        chk("fill_adr", wb_adr_o, exp_adr);
        chk("fill_cti", wb_cti_o, (b == N - 1) ? EXP_EOB : EXP_INCR);
        chk("fill_bte", wb_bte_o, EXP_BTE);
        if (w == waits && b != err_beat) exp_q.push_back({exp_adr[AW-1:0], wb_dat_i});
        @(posedge clk_i); #1;
        edges++;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
      if (b == err_beat) begin
        exp_errs++;
        @(negedge clk_i);
        chk("err_pulse", err_o, 1);
        chk("err_cyc", wb_cyc_o, 0);
        chk("err_busy", busy_o, 0);
        chk("err_no_ack", ack_o, 0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("err_one_cycle", err_o, 0);
        chk("err_idle", busy_o, 0);
        return;
      end
      idx = idx + 1'b1;
    end
    @(negedge clk_i);
    chk("flush_cyc", wb_cyc_o, 0);
    chk("flush_busy", busy_o, 1);
    chk("flush_ack", ack_o, 0);
    @(posedge clk_i); #1;
    edges++;
    exp_acks++;
    @(negedge clk_i);
    chk("done_ack", ack_o, 1);
    chk("done_busy", busy_o, 1);
    chk("done_edges", edges, N + total_waits + 1);
    @(posedge clk_i); #1;
    if (!next_v) begin
      @(negedge clk_i);
      chk("post_ack", ack_o, 0);
      chk("post_busy", busy_o, 0);
    end
  endtask

  task automatic reset_mid_fill();
    logic [XAW-1:0] a;
    req_i = 1'b1;
    req_adr_i = 30'h300;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      a = 30'h300 + XAW'(b);
      wb_ack_i = 1'b1;
      wb_dat_i = $urandom;
      @(negedge clk_i);
      exp_q.push_back({a[AW-1:0], wb_dat_i});
      @(posedge clk_i); #1;
      wb_ack_i = 1'b0;
    end
    #2;
    rst_i = 1'b1;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    req_i = 1'b0;
    req_adr_i = '0;
    wb_dat_i = '0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    #1;
    chk_all_zero("rst");
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_busy", busy_o, 0);
    chk("idle_cyc", wb_cyc_o, 0);

    run_fill(30'h104, 0, -1, 1'b0, '0, 1'b0);
    run_fill(30'h106, 0, -1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) run_fill(XAW'($urandom), 3, -1, 1'b0, '0, 1'b0);
    run_fill(30'h200, 0, 2, 1'b0, '0, 1'b0);
    run_fill(30'h0a7, 2, 1, 1'b0, '0, 1'b0);
    reset_mid_fill();
    run_fill(30'h3c5, 1, -1, 1'b0, '0, 1'b0);
    run_fill(30'h1f5, 1, -1, 1'b1, 30'h2a2, 1'b0);
    run_fill(30'h2a2, 1, -1, 1'b0, '0, 1'b1);

    repeat (2) @(negedge clk_i);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("ack_pulse_count", n_ack_seen, exp_acks);
    chk("err_pulse_count", n_err_seen, exp_errs);
    chk("final_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
